div_iter: RTL

//  Multi-cycle radix-2 restoring divider serving the EX-stage DIV/DIVU start/ready handshake.
//  EX holds start_i and operands stable and stalls until ready_o is high.
//  The block returns {remainder, quotient} for the MEM/WB stages to write into HI/LO.
//  One division is in flight at a time. Signed and unsigned divides are both supported.

---
 rtl/div_iter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX-stage DIV/DIVU handshake.
// Returns {remainder, quotient}; one divide in flight, DATA_W iterations each.
//
// state  | meaning
// IDLE   | waiting for start_i with annul_i low
// BYZERO | divisor was zero; zero result issued on the next edge
// ON     | one shift/subtract iteration per edge
// END    | result_o/ready_o held until start_i drops
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_neg_quo;
  logic                r_neg_rem;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  state_t              w_state_nx;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [DATA_W-1:0]   w_rem_nx;
  logic [DATA_W-1:0]   w_quo_nx;
  logic [DATA_W-1:0]   w_divisor_nx;
  logic                w_neg_quo_nx;
  logic                w_neg_rem_nx;
  logic [2*DATA_W-1:0] w_result_nx;
  logic                w_ready_nx;

  logic                w_op1_neg;
  logic                w_op2_neg;
  logic [DATA_W-1:0]   w_abs1;
  logic [DATA_W-1:0]   w_abs2;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_trial;
  logic                w_borrow;
  logic [DATA_W-1:0]   w_rem_it;
  logic [DATA_W-1:0]   w_quo_it;
  logic [DATA_W-1:0]   w_rem_fix;
  logic [DATA_W-1:0]   w_quo_fix;

  // Magnitudes are taken mod 2^DATA_W, so the most negative value maps onto itself.
  assign w_op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign w_op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign w_abs1    = w_op1_neg ? -opdata1_i : opdata1_i;
  assign w_abs2    = w_op2_neg ? -opdata2_i : opdata2_i;

  // Partial remainder stays below the divisor, so DATA_W+1 bits hold the shifted value.
  assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_divisor};
  assign w_borrow  = w_trial[DATA_W];
  assign w_rem_it  = w_borrow ? w_rem_sh[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_quo_it  = {r_quo[DATA_W-2:0], ~w_borrow};
  assign w_rem_fix = r_neg_rem ? -w_rem_it : w_rem_it;
  assign w_quo_fix = r_neg_quo ? -w_quo_it : w_quo_it;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_rem_nx     = r_rem;
    w_quo_nx     = r_quo;
    w_divisor_nx = r_divisor;
    w_neg_quo_nx = r_neg_quo;
    w_neg_rem_nx = r_neg_rem;
    w_result_nx  = r_result;
    w_ready_nx   = r_ready;
    case (r_state)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nx = S_BYZERO;
          end else begin
            w_state_nx   = S_ON;
            w_rem_nx     = '0;
            w_quo_nx     = w_abs1;
            w_divisor_nx = w_abs2;
            w_neg_quo_nx = w_op1_neg ^ w_op2_neg;
            w_neg_rem_nx = w_op1_neg;
            w_cnt_nx     = '0;
          end
        end
      end
      S_BYZERO: begin
        w_result_nx = '0;
        if (annul_i) begin
          w_state_nx = S_IDLE;
          w_ready_nx = 1'b0;
        end else begin
          w_state_nx = S_END;
          w_ready_nx = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nx  = S_IDLE;
          w_ready_nx  = 1'b0;
          w_result_nx = '0;
        end else begin
          w_rem_nx = w_rem_it;
          w_quo_nx = w_quo_it;
          w_cnt_nx = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            w_state_nx  = S_END;
            w_result_nx = {w_rem_fix, w_quo_fix};
            w_ready_nx  = 1'b1;
          end
        end
      end
      S_END: begin
        if (!start_i) begin
          w_state_nx  = S_IDLE;
          w_ready_nx  = 1'b0;
          w_result_nx = '0;
        end
      end
      default: begin
        w_state_nx  = S_IDLE;
        w_ready_nx  = 1'b0;
        w_result_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_rem     <= w_rem_nx;
      r_quo     <= w_quo_nx;
      r_divisor <= w_divisor_nx;
      r_neg_quo <= w_neg_quo_nx;
      r_neg_rem <= w_neg_rem_nx;
      r_result  <= w_result_nx;
      r_ready   <= w_ready_nx;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule
